id_ex_elastic_buf: RTL and testbench

//  Parametrised ID/EX pipeline buffer between decode and execute. Holds the EX/MEM/WB

---
 rtl/id_ex_elastic_buf.sv | 115 +++++++++++
 tb/tb_id_ex_elastic_buf.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_elastic_buf.sv
// id_ex_elastic_buf: ID/EX elastic queue with valid/ready handshakes, flush and NOP bubbles
module id_ex_elastic_buf #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int IMM_W  = 16,
    parameter int EX_W   = 4,
    parameter int MEM_W  = 3,
    parameter int WB_W   = 2,
    parameter int DEPTH  = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EX_W-1:0]   i_ex,
    input  logic [MEM_W-1:0]  i_mem,
    input  logic [WB_W-1:0]   i_wb,
    input  logic [DATA_W-1:0] i_rd1,
    input  logic [DATA_W-1:0] i_rd2,
    input  logic [RD_W-1:0]   i_rd,
    input  logic [IMM_W-1:0]  i_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EX_W-1:0]   o_ex,
    output logic [MEM_W-1:0]  o_mem,
    output logic [WB_W-1:0]   o_wb,
    output logic [DATA_W-1:0] o_rd1,
    output logic [DATA_W-1:0] o_rd2,
    output logic [RD_W-1:0]   o_rd,
    output logic [IMM_W-1:0]  o_imm,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef struct packed {
        logic [EX_W-1:0]   ex;
        logic [MEM_W-1:0]  mem;
        logic [WB_W-1:0]   wb;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [RD_W-1:0]   rd;
        logic [IMM_W-1:0]  imm;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    entry_t           in_entry, out_entry;

    // Handshake flags come only from registered occupancy, so async reset clears them at once
    assign out_valid = count_q != '0;
    assign in_ready  = count_q < FULL_CNT;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign in_entry = '{ex: i_ex, mem: i_mem, wb: i_wb, rd1: i_rd1, rd2: i_rd2, rd: i_rd, imm: i_imm};

    // An empty queue presents an all-zero bubble so execute never sees a stale instruction
    assign out_entry = out_valid ? mem_q[rd_ptr_q] : '0;
    assign o_ex      = out_entry.ex;
    assign o_mem     = out_entry.mem;
    assign o_wb      = out_entry.wb;
    assign o_rd1     = out_entry.rd1;
    assign o_rd2     = out_entry.rd2;
    assign o_rd      = out_entry.rd;
    assign o_imm     = out_entry.imm;
    assign count     = count_q;

    // Next queue state: flush wins over push and pop; pointers wrap at DEPTH-1
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_entry;
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: it is only visible while count is non-zero
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_id_ex_elastic_buf.sv
// tb_id_ex_elastic_buf: directed checks of the ID/EX elastic buffer at DEPTH=2 and DEPTH=3
module tb_id_ex_elastic_buf;
    logic        clock = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [3:0]  i_ex, o_ex;
    logic [2:0]  i_mem, o_mem;
    logic [1:0]  i_wb, o_wb;
    logic [31:0] i_rd1, i_rd2, o_rd1, o_rd2;
    logic [4:0]  i_rd, o_rd;
    logic [15:0] i_imm, o_imm;
    logic [1:0]  count;

    logic        flush3, in_valid3, out_ready3, in_ready3, out_valid3;
    logic [3:0]  o_ex3;
    logic [2:0]  o_mem3;
    logic [1:0]  o_wb3;
    logic [31:0] o_rd13, o_rd23;
    logic [4:0]  o_rd3;
    logic [15:0] o_imm3;
    logic [1:0]  count3;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    id_ex_elastic_buf dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .i_ex(i_ex), .i_mem(i_mem), .i_wb(i_wb), .i_rd1(i_rd1), .i_rd2(i_rd2),
        .i_rd(i_rd), .i_imm(i_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .o_ex(o_ex), .o_mem(o_mem), .o_wb(o_wb), .o_rd1(o_rd1), .o_rd2(o_rd2),
        .o_rd(o_rd), .o_imm(o_imm), .count(count)
    );

    id_ex_elastic_buf #(.DEPTH(3)) dut3 (
        .clock(clock), .reset(reset), .flush(flush3),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .i_ex(i_ex), .i_mem(i_mem), .i_wb(i_wb), .i_rd1(i_rd1), .i_rd2(i_rd2),
        .i_rd(i_rd), .i_imm(i_imm),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .o_ex(o_ex3), .o_mem(o_mem3), .o_wb(o_wb3), .o_rd1(o_rd13), .o_rd2(o_rd23),
        .o_rd(o_rd3), .o_imm(o_imm3), .count(count3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int q[$];
        int sent;
        int got;
        logic push, pop;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        flush3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0;
        i_ex = '0; i_mem = '0; i_wb = '0; i_rd1 = '0; i_rd2 = '0; i_rd = '0; i_imm = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_o_ex", o_ex, 0);

        // single pass through an empty queue
        in_valid = 1'b1; out_ready = 1'b1;
        i_rd1 = 32'hDEADBEEF; i_rd2 = 32'h12345678; i_rd = 5'd7; i_ex = 4'hA;
        i_mem = 3'h5; i_wb = 2'h3; i_imm = 16'hBEEF;
        tick();
        in_valid = 1'b0;
        chk("sp_out_valid", out_valid, 1);
        chk("sp_o_rd1", o_rd1, 32'hDEADBEEF);
        chk("sp_o_rd2", o_rd2, 32'h12345678);
        chk("sp_o_rd", o_rd, 7);
        chk("sp_o_ex", o_ex, 4'hA);
        chk("sp_o_mem", o_mem, 3'h5);
        chk("sp_o_wb", o_wb, 2'h3);
        chk("sp_o_imm", o_imm, 16'hBEEF);
        chk("sp_count", count, 1);
        tick();
        chk("sp_bubble_valid", out_valid, 0);
        chk("sp_bubble_ex", o_ex, 0);
        chk("sp_bubble_rd1", o_rd1, 0);
        chk("sp_bubble_imm", o_imm, 0);
        chk("sp_count0", count, 0);

        // fill to DEPTH=2 with backpressure, then drain in order
        out_ready = 1'b0; in_valid = 1'b1; i_ex = 4'h1; i_imm = 16'd1;
        tick();
        chk("fill_count1", count, 1);
        i_imm = 16'd2;
        tick();
        chk("fill_count2", count, 2);
        chk("fill_in_ready", in_ready, 0);
        i_imm = 16'd3;
        tick();
        chk("fill_hold_count", count, 2);
        chk("fill_head1", o_imm, 1);
        out_ready = 1'b1;
        tick();
        chk("drain_head2", o_imm, 2);
        chk("drain_count1", count, 1);
        chk("drain_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("drain_head3", o_imm, 3);
        chk("drain_count_pp", count, 1);
        tick();
        chk("drain_empty", out_valid, 0);

        // streaming push/pop at count=1 across many pointer wraps
        in_valid = 1'b1; out_ready = 1'b1; i_imm = 16'd0;
        tick();
        chk("pp_head0", o_imm, 0);
        for (int k = 1; k < 10; k++) begin
            i_imm = 16'(k);
            tick();
            chk("pp_count", count, 1);
            chk("pp_head", o_imm, 64'(k));
        end
        in_valid = 1'b0;
        tick();
        chk("pp_empty", count, 0);

        // flush at count=2 with in_valid held
        out_ready = 1'b0; in_valid = 1'b1; i_ex = 4'h5; i_imm = 16'h11;
        tick();
        i_imm = 16'h12;
        tick();
        chk("fl_count2", count, 2);
        i_imm = 16'h13; flush = 1'b1;
        tick();
        chk("fl_count", count, 0);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        chk("fl_o_ex", o_ex, 0);
        chk("fl_o_imm", o_imm, 0);
        // flush while a push would otherwise be accepted
        i_imm = 16'h14;
        tick();
        chk("fl2_count", count, 0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("fl2_out_valid", out_valid, 0);
        chk("fl2_o_imm", o_imm, 0);

        // asynchronous reset mid-cycle with count=2
        out_ready = 1'b0; in_valid = 1'b1; i_ex = 4'h9; i_imm = 16'h21;
        tick();
        i_imm = 16'h22;
        tick();
        in_valid = 1'b0;
        chk("ar_pre_count", count, 2);
        #3 reset = 1'b1;
        #1;
        chk("ar_count", count, 0);
        chk("ar_out_valid", out_valid, 0);
        chk("ar_o_ex", o_ex, 0);
        chk("ar_in_ready", in_ready, 1);
        #1 reset = 1'b0;
        tick();
        chk("ar_post_count", count, 0);

        // DEPTH=3 regression with random out_ready against a FIFO model
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 200 && got < 7; cyc++) begin
            chk("d3_count", count3, 64'(q.size()));
            chk("d3_in_ready", in_ready3, 64'(q.size() < 3));
            chk("d3_out_valid", out_valid3, 64'(q.size() != 0));
            if (q.size() != 0) chk("d3_head", o_imm3, 64'(q[0]));
            in_valid3 = sent < 7;
            out_ready3 = cyc < 6 ? 1'b0 : 1'($urandom_range(0, 1));
            i_imm = 16'(16'h100 + sent);
            push = in_valid3 && q.size() < 3;
            pop = out_ready3 && q.size() != 0;
            tick();
            if (pop) begin
                void'(q.pop_front());
                got++;
            end
            if (push) begin
                q.push_back(16'h100 + sent);
                sent++;
            end
        end
        chk("d3_all_drained", got, 7);
        in_valid3 = 1'b0; out_ready3 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
